// File: rtl/motor_out_n.sv
// motor_out_n: multi-channel ESC output engine.
//
// Latches a packed vector of motor commands on UPDATE and transmits one frame
// on every channel in parallel, either as DShot or as standard servo PWM.
// All channels share the same timing counters, so their edges are
// cycle-aligned. A frame already in flight is never disturbed. Commands that
// arrive during a frame are held in a shadow set and sent as the next frame.
//
// Ports:
//   clk         system clock (BASE_FREQ Hz)
//   reset_n     asynchronous active-low reset
//   update      one-cycle pulse: latch values/telem_req, request a frame
//   values      packed commands, motor i at [i*VALUE_WIDTH +: VALUE_WIDTH]
//   telem_req   per-channel DShot telemetry request bit
//   mode        0 = PWM, 1 = DShot (sampled at frame start)
//   armed       0 forces command 0 / telemetry 0 (sampled at frame start)
//   busy        frame in progress or pending
//   frame_done  one-cycle pulse at the end of each frame
//   motor       registered ESC output lines
//
// state | meaning
// IDLE  | no frame; wait for a pending request
// LOAD  | one cycle: sample mode/armed, build per-channel data, clear pending
// DSHOT | 16 DShot bits followed by DSHOT_GAP_BITS low bit periods
// PWM   | one PWM period
// DONE  | one cycle: frame_done pulse, chain to LOAD if more is pending

module motor_out_n #(
    parameter int BASE_FREQ      = 100_000_000,
    parameter int NUM_MOTORS     = 4,
    parameter int VALUE_WIDTH    = 11,
    parameter int DSHOT_RATE     = 600_000,
    parameter int DSHOT_GAP_BITS = 2
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              update,
    input  logic [NUM_MOTORS*VALUE_WIDTH-1:0] values,
    input  logic [NUM_MOTORS-1:0]             telem_req,
    input  logic                              mode,
    input  logic                              armed,
    output logic                              busy,
    output logic                              frame_done,
    output logic [NUM_MOTORS-1:0]             motor
);

    localparam int T_BIT      = BASE_FREQ / DSHOT_RATE;
    localparam int T1         = T_BIT * 3 / 4;
    localparam int T0         = T_BIT * 3 / 8;
    localparam int PWM_MIN    = BASE_FREQ / 1000;
    localparam int PWM_STEP   = BASE_FREQ / 2_048_000;
    localparam int PWM_PERIOD = BASE_FREQ / 500;
    localparam int LAST_BIT   = 16 + DSHOT_GAP_BITS - 1;

    localparam int PH_W = (T_BIT > 2) ? $clog2(T_BIT) : 1;
    localparam int BI_W = $clog2(LAST_BIT + 1);
    localparam int PC_W = $clog2(PWM_PERIOD);
    localparam int TH_W = PC_W + 1;

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(T_BIT - 1);
    localparam logic [PH_W-1:0] T1_C    = PH_W'(T1);
    localparam logic [PH_W-1:0] T0_C    = PH_W'(T0);
    localparam logic [BI_W-1:0] BI_LAST = BI_W'(LAST_BIT);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PWM_PERIOD - 1);

    typedef enum logic [2:0] {IDLE, LOAD, DSHOT, PWM, DONE} state_t;

    state_t state, state_d;

    logic [PH_W-1:0] phase, phase_d;
    logic [BI_W-1:0] bit_idx, bit_d;
    logic [PC_W-1:0] pcnt, pcnt_d;

    logic [NUM_MOTORS*VALUE_WIDTH-1:0] sh_values;
    logic [NUM_MOTORS-1:0]             sh_telem;
    logic                              pending;

    logic [15:0]     work_frame [NUM_MOTORS];
    logic [TH_W-1:0] work_thr   [NUM_MOTORS];
    logic [11:0]     word12     [NUM_MOTORS];
    logic [15:0]     load_frame [NUM_MOTORS];
    logic [TH_W-1:0] load_thr   [NUM_MOTORS];
    logic [15:0]     sel_frame  [NUM_MOTORS];
    logic [TH_W-1:0] sel_thr    [NUM_MOTORS];
    logic [NUM_MOTORS-1:0] motor_d;
    logic [3:0]      bit_sel;

    function automatic logic [3:0] crc4(input logic [11:0] w);
        crc4 = w[3:0] ^ w[7:4] ^ w[11:8];
    endfunction

    // Shadow set: a new UPDATE overrides the pending clear done by LOAD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_values <= '0;
            sh_telem  <= '0;
            pending   <= 1'b0;
        end else if (update) begin
            sh_values <= values;
            sh_telem  <= telem_req;
            pending   <= 1'b1;
        end else if (state == LOAD) begin
            pending   <= 1'b0;
        end
    end

    // Per-channel working data as it would be built from the shadow this cycle.
    always_comb begin
        for (int i = 0; i < NUM_MOTORS; i++) begin
            word12[i]     = armed ? {11'(sh_values[i*VALUE_WIDTH +: VALUE_WIDTH]), sh_telem[i]}
                                  : 12'd0;
            load_frame[i] = {word12[i], crc4(word12[i])};
            load_thr[i]   = armed ? TH_W'(PWM_MIN + int'(sh_values[i*VALUE_WIDTH +: VALUE_WIDTH]) * PWM_STEP)
                                  : TH_W'(PWM_MIN);
        end
    end

    always_comb begin
        state_d = state;
        phase_d = phase;
        bit_d   = bit_idx;
        pcnt_d  = pcnt;
        unique case (state)
            IDLE: begin
                if (pending) state_d = LOAD;
            end
            LOAD: begin
                phase_d = '0;
                bit_d   = '0;
                pcnt_d  = '0;
                state_d = mode ? DSHOT : PWM;
            end
            DSHOT: begin
                if (phase == PH_LAST) begin
                    phase_d = '0;
                    if (bit_idx == BI_LAST) state_d = DONE;
                    else                    bit_d   = bit_idx + 1'b1;
                end else begin
                    phase_d = phase + 1'b1;
                end
            end
            PWM: begin
                if (pcnt == PC_LAST) state_d = DONE;
                else                 pcnt_d  = pcnt + 1'b1;
            end
            DONE: begin
                // An UPDATE landing in this cycle is already in the shadow
                // by the time LOAD reads it.
                state_d = (pending || update) ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The output register is loaded from next-cycle counters so the line
    // rises on the very edge that enters DSHOT/PWM. During LOAD the freshly
    // built data is used directly since the working registers load on that
    // same edge.
    always_comb begin
        bit_sel = 4'd15 - bit_d[3:0];
        for (int i = 0; i < NUM_MOTORS; i++) begin
            sel_frame[i] = (state == LOAD) ? load_frame[i] : work_frame[i];
            sel_thr[i]   = (state == LOAD) ? load_thr[i]   : work_thr[i];
            motor_d[i]   = 1'b0;
            if (state_d == DSHOT) begin
                if (int'(bit_d) < 16)
                    motor_d[i] = phase_d < (sel_frame[i][bit_sel] ? T1_C : T0_C);
            end else if (state_d == PWM) begin
                motor_d[i] = {1'b0, pcnt_d} < sel_thr[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            phase   <= '0;
            bit_idx <= '0;
            pcnt    <= '0;
            motor   <= '0;
            for (int i = 0; i < NUM_MOTORS; i++) begin
                work_frame[i] <= '0;
                work_thr[i]   <= '0;
            end
        end else begin
            state   <= state_d;
            phase   <= phase_d;
            bit_idx <= bit_d;
            pcnt    <= pcnt_d;
            motor   <= motor_d;
            if (state == LOAD) begin
                for (int i = 0; i < NUM_MOTORS; i++) begin
                    work_frame[i] <= load_frame[i];
                    work_thr[i]   <= load_thr[i];
                end
            end
        end
    end

    assign busy       = (state != IDLE) || pending;
    assign frame_done = (state == DONE);

endmodule

// File: tb/tb_motor_out_n.sv
module tb_motor_out_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        upd_d, upd_p, upd_8;
    logic [43:0] values;
    logic [3:0]  telem;
    logic        mode, armed;
    logic [87:0] values8;
    logic [7:0]  telem8;
    logic        busy_d, done_d, busy_p, done_p, busy_8, done_8;
    logic [3:0]  motor_d, motor_p;
    logic [7:0]  motor_8;

    // Default clocking for DShot checks.
    motor_out_n u_d (
        .clk(clk), .reset_n(reset_n), .update(upd_d), .values(values),
        .telem_req(telem), .mode(mode), .armed(armed),
        .busy(busy_d), .frame_done(done_d), .motor(motor_d)
    );

    // Scaled clock so a PWM period is 8192 cycles: MIN 4096, STEP 2.
    motor_out_n #(.BASE_FREQ(4_096_000)) u_p (
        .clk(clk), .reset_n(reset_n), .update(upd_p), .values(values),
        .telem_req(telem), .mode(mode), .armed(armed),
        .busy(busy_p), .frame_done(done_p), .motor(motor_p)
    );

    motor_out_n #(.NUM_MOTORS(8)) u_8 (
        .clk(clk), .reset_n(reset_n), .update(upd_8), .values(values8),
        .telem_req(telem8), .mode(mode), .armed(armed),
        .busy(busy_8), .frame_done(done_8), .motor(motor_8)
    );

    int checks = 0;
    int errors = 0;
    int sel_g  = 0;

    logic [7:0] cur_motor;
    logic       cur_busy, cur_done;
    always_comb begin
        case (sel_g)
            1:       begin cur_motor = {4'b0, motor_p}; cur_busy = busy_p; cur_done = done_p; end
            2:       begin cur_motor = motor_8;          cur_busy = busy_8; cur_done = done_8; end
            default: begin cur_motor = {4'b0, motor_d}; cur_busy = busy_d; cur_done = done_d; end
        endcase
    end

    typedef struct {
        int          sel;
        logic        arm;
        logic        md;
        logic [43:0] vals;
        logic [3:0]  tel;
        int          exp [4];
        int          exp_len;
    } vec_t;

    vec_t vec [5];

    int          pulse_cnt [8];
    logic [31:0] bits_rx   [8];
    int          hi_tot    [8];
    int          align_err, busy_drop, n_done;
    int          done_at   [2];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic set_upd(input int sel, input logic v);
        case (sel)
            1:       upd_p = v;
            2:       upd_8 = v;
            default: upd_d = v;
        endcase
    endtask

    function automatic logic [15:0] dshot_word(input logic [10:0] v, input logic t);
        logic [11:0] w;
        logic [11:0] c;
        w = {v, t};
        c = (w ^ (w >> 4) ^ (w >> 8)) & 12'hF;
        return {w, c[3:0]};
    endfunction

    // Issues UPDATE, then watches the selected instance cycle by cycle
    // (k = cycles after the sampling edge) until nfr frame_done pulses.
    // Every pulse must start at frame_base + 2 + bit*tb; tb = 0 means PWM.
    task automatic run_frames(input int sel, input int nfr, input int tb, input int frl,
                              input int max_k, input int inj_k1, input int inj_k2,
                              input logic [43:0] inj_v1, input logic [43:0] inj_v2,
                              input bit wiggle);
        int run [8];
        int k;
        int t1;
        int t0;
        int exp_start;
        t1 = tb * 3 / 4;
        t0 = tb * 3 / 8;
        sel_g = sel;
        for (int i = 0; i < 8; i++) begin
            pulse_cnt[i] = 0; bits_rx[i] = '0; hi_tot[i] = 0; run[i] = 0;
        end
        align_err = 0; busy_drop = 0; n_done = 0;
        done_at[0] = -1; done_at[1] = -1;
        @(negedge clk);
        set_upd(sel, 1'b1);
        @(negedge clk);
        set_upd(sel, 1'b0);
        k = 0;
        while (n_done < nfr && k <= max_k) begin
            if (!cur_busy) busy_drop++;
            for (int i = 0; i < 8; i++) begin
                if (cur_motor[i]) begin
                    exp_start = (pulse_cnt[i] / 16) * frl + 2 + (pulse_cnt[i] % 16) * tb;
                    if (run[i] == 0 && k != exp_start) align_err++;
                    run[i]++;
                    hi_tot[i]++;
                end else if (run[i] > 0) begin
                    if (tb > 0 && run[i] != t1 && run[i] != t0) align_err++;
                    bits_rx[i] = {bits_rx[i][30:0], (run[i] == t1)};
                    pulse_cnt[i]++;
                    run[i] = 0;
                end
            end
            if (cur_done) begin
                if (n_done < 2) done_at[n_done] = k;
                n_done++;
            end
            if (k == inj_k1) begin
                values = inj_v1; set_upd(sel, 1'b1);
            end else if (k == inj_k2) begin
                values = inj_v2; set_upd(sel, 1'b1);
            end else if (k == inj_k1 + 1 || k == inj_k2 + 1) begin
                set_upd(sel, 1'b0);
            end
            if (wiggle && k == 700)  begin armed = 1'b0; mode = 1'b0; end
            if (wiggle && k == 1500) begin armed = 1'b1; mode = 1'b1; end
            k++;
            @(negedge clk);
        end
        chk("frames seen", n_done, nfr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int tb;
        reset_n = 1'b0;
        upd_d = 1'b0; upd_p = 1'b0; upd_8 = 1'b0;
        values = '0; telem = '0; mode = 1'b1; armed = 1'b1;
        values8 = '0; telem8 = '0;

        vec[0] = '{0, 1'b1, 1'b1, {11'd1, 11'd2047, 11'd48, 11'd1046}, 4'b1010,
                   '{32'h82C6, 32'h0617, 32'hFFEE, 32'h0033}, 2990};
        vec[1] = '{0, 1'b0, 1'b1, {11'd2000, 11'd2000, 11'd2000, 11'd2000}, 4'b1111,
                   '{0, 0, 0, 0}, 2990};
        vec[2] = '{0, 1'b1, 1'b1, {11'd555, 11'd0, 11'd1024, 11'd2000}, 4'b0001,
                   '{32'hFA14, 32'h8008, 32'h0000, 32'h4567}, 2990};
        vec[3] = '{1, 1'b1, 1'b0, {11'd500, 11'd2047, 11'd1024, 11'd0}, 4'b1111,
                   '{4096, 6144, 8190, 5096}, 8194};
        vec[4] = '{1, 1'b0, 1'b0, {11'd7, 11'd100, 11'd2047, 11'd2047}, 4'b0000,
                   '{4096, 4096, 4096, 4096}, 8194};

        repeat (3) @(negedge clk);
        chk("in reset motor_d", motor_d, 0);
        chk("in reset busy_d", busy_d, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("after reset motor_d", motor_d, 0);
        chk("after reset busy_d", busy_d, 0);
        chk("after reset done_d", done_d, 0);
        chk("after reset motor_p", motor_p, 0);
        chk("after reset motor_8", motor_8, 0);

        for (int r = 0; r < 5; r++) begin
            values = vec[r].vals; telem = vec[r].tel;
            mode = vec[r].md; armed = vec[r].arm;
            tb = (vec[r].sel == 1) ? 0 : 166;
            run_frames(vec[r].sel, 1, tb, vec[r].exp_len, vec[r].exp_len + 50,
                       -1, -1, '0, '0, 1'b0);
            chk($sformatf("row%0d frame length", r), done_at[0], vec[r].exp_len);
            for (int ch = 0; ch < 4; ch++) begin
                if (vec[r].md) begin
                    chk($sformatf("row%0d ch%0d pulses", r, ch), pulse_cnt[ch], 16);
                    chk($sformatf("row%0d ch%0d word", r, ch), bits_rx[ch][15:0], vec[r].exp[ch]);
                end else begin
                    chk($sformatf("row%0d ch%0d pulses", r, ch), pulse_cnt[ch], 1);
                    chk($sformatf("row%0d ch%0d high time", r, ch), hi_tot[ch], vec[r].exp[ch]);
                end
            end
            chk($sformatf("row%0d alignment", r), align_err, 0);
            chk($sformatf("row%0d busy drop", r), busy_drop, 0);
            chk($sformatf("row%0d busy after", r), cur_busy, 0);
            chk($sformatf("row%0d done single", r), cur_done, 0);
        end

        // Two updates during a DShot frame plus mode/armed wiggle mid-frame.
        values = {33'd0, 11'd1046}; telem = '0; mode = 1'b1; armed = 1'b1;
        run_frames(0, 2, 166, 2990, 6200, 500, 1000,
                   {33'd0, 11'd100}, {33'd0, 11'd200}, 1'b1);
        chk("b2b first done", done_at[0], 2990);
        chk("b2b second done", done_at[1], 5980);
        chk("b2b ch0 pulses", pulse_cnt[0], 32);
        chk("b2b ch0 frame1", bits_rx[0][31:16], 16'h82C6);
        chk("b2b ch0 frame2", bits_rx[0][15:0], 16'h1908);
        chk("b2b ch1 frames", bits_rx[1], 0);
        chk("b2b alignment", align_err, 0);
        chk("b2b busy drop", busy_drop, 0);
        chk("b2b busy after", cur_busy, 0);

        // Eight channels, distinct commands.
        for (int i = 0; i < 8; i++) values8[i*11 +: 11] = 11'(150 * i + 33);
        telem8 = 8'hA5; mode = 1'b1; armed = 1'b1;
        run_frames(2, 1, 166, 2990, 3100, -1, -1, '0, '0, 1'b0);
        chk("m8 frame length", done_at[0], 2990);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("m8 ch%0d pulses", i), pulse_cnt[i], 16);
            chk($sformatf("m8 ch%0d word", i), bits_rx[i][15:0],
                dshot_word(values8[i*11 +: 11], telem8[i]));
        end
        chk("m8 alignment", align_err, 0);

        // Asynchronous reset during bit 7.
        sel_g = 0;
        values = {33'd0, 11'd1046}; mode = 1'b1; armed = 1'b1;
        @(negedge clk);
        upd_d = 1'b1;
        @(negedge clk);
        upd_d = 1'b0;
        repeat (1169) @(negedge clk);
        chk("reset pre motor0", motor_d[0], 1);
        chk("reset pre busy", busy_d, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("reset async motor", motor_d, 0);
        chk("reset async busy", busy_d, 0);
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        repeat (3500) begin
            @(negedge clk);
            if (motor_d != 0 || busy_d || done_d) cnt++;
        end
        chk("reset stays quiet", cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
